lemmings_dig_arbiter: RTL and testbench



---
 rtl/lemmings_dig_arbiter_if.sv | 37 +++
 rtl/lemmings_dig_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_lemmings_dig_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lemmings_dig_arbiter_if.sv
// Bundle between the dig-tool arbiter (master) and the lemming FSMs (slave).
// With LEMMINGS_ARB_STATS_EN defined, the grant/revoke statistics counters join the bundle.
interface lemmings_dig_arbiter_if #(
   parameter int N = 4
) ();
   localparam int IW = $clog2(N);

   logic [N-1:0]  req;
   logic [N-1:0]  busy;
   logic [N-1:0]  dig;
   logic          grant_valid;
   logic [IW-1:0] grant_id;
   logic          revoke;
   logic          cooling;
`ifdef LEMMINGS_ARB_STATS_EN
   logic [15:0]   grant_count;
   logic [7:0]    revoke_count;

   modport master (
      input  req, busy,
      output dig, grant_valid, grant_id, revoke, cooling, grant_count, revoke_count
   );
   modport slave (
      output req, busy,
      input  dig, grant_valid, grant_id, revoke, cooling, grant_count, revoke_count
   );
`else
   modport master (
      input  req, busy,
      output dig, grant_valid, grant_id, revoke, cooling
   );
   modport slave (
      output req, busy,
      input  dig, grant_valid, grant_id, revoke, cooling
   );
`endif
endinterface

// File: rtl/lemmings_dig_arbiter.sv
// Round-robin arbiter sharing one dig tool among N lemmings, with hold timeout and cooldown.
// Optional statistics counters are enabled by LEMMINGS_ARB_STATS_EN.
module lemmings_dig_arbiter #(
   parameter int N        = 4,
   parameter int COOLDOWN = 3,
   parameter int MAX_HOLD = 16
) (
   input logic                    clk,
   input logic                    reset,
   lemmings_dig_arbiter_if.master bus
);
   localparam int IW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD);
   localparam int CW = $clog2(COOLDOWN + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_COOL  = 3'd4;

   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN - 1);
   localparam logic [IW-1:0] ID_LAST   = IW'(N - 1);

   logic [2:0]    state_q, state_d;
   logic [IW-1:0] grant_id_q, grant_id_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic          wait_cnt_q, wait_cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [CW-1:0] cool_cnt_q, cool_cnt_d;
   logic [N-1:0]  dig_q, dig_d;
   logic          grant_valid_q, grant_valid_d;
   logic          revoke_q, revoke_d;
   logic          cooling_q, cooling_d;

   logic          win_found_s;
   logic [IW-1:0] win_id_s;
   logic          busy_sel_s;

   assign busy_sel_s = bus.busy[grant_id_q];

   // Round-robin search: first requester at or above rr_ptr, wrapping modulo N
   always_comb begin
      int idx_v;
      idx_v       = 0;
      win_found_s = 1'b0;
      win_id_s    = {IW{1'b0}};
      for (int i = 0; i < N; i++) begin
         idx_v = int'(rr_ptr_q) + i;
         if (idx_v >= N) begin
            idx_v = idx_v - N;
         end else begin
            idx_v = idx_v;
         end
         if (!win_found_s && bus.req[IW'(idx_v)]) begin
            win_found_s = 1'b1;
            win_id_s    = IW'(idx_v);
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next-state logic for the grant FSM and its counters
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      wait_cnt_d = wait_cnt_q;
      hold_cnt_d = hold_cnt_q;
      cool_cnt_d = cool_cnt_q;
      revoke_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_found_s) begin
               state_d    = S_GRANT;
               grant_id_d = win_id_s;
               rr_ptr_d   = (win_id_s == ID_LAST) ? {IW{1'b0}} : win_id_s + IW'(1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            state_d    = S_WAIT;
            wait_cnt_d = 1'b0;
         end
         S_WAIT: begin
            if (busy_sel_s) begin
               state_d    = S_HOLD;
               hold_cnt_d = {HW{1'b0}};
            end else if (wait_cnt_q) begin
               state_d    = S_COOL;
               cool_cnt_d = {CW{1'b0}};
            end else begin
               wait_cnt_d = 1'b1;
            end
         end
         S_HOLD: begin
            // A release wins over a timeout landing on the same cycle
            if (!busy_sel_s) begin
               state_d    = S_COOL;
               cool_cnt_d = {CW{1'b0}};
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = S_COOL;
               cool_cnt_d = {CW{1'b0}};
               revoke_d   = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         S_COOL: begin
            if (cool_cnt_q == COOL_LAST) begin
               state_d    = S_IDLE;
               cool_cnt_d = {CW{1'b0}};
            end else begin
               cool_cnt_d = cool_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore output decode from the next state so outputs register alongside it
   always_comb begin
      dig_d         = {N{1'b0}};
      grant_valid_d = 1'b0;
      cooling_d     = 1'b0;
      if (state_d == S_GRANT) begin
         dig_d = {{(N-1){1'b0}}, 1'b1} << grant_id_d;
      end else begin
         dig_d = {N{1'b0}};
      end
      grant_valid_d = (state_d == S_GRANT) || (state_d == S_WAIT) || (state_d == S_HOLD);
      cooling_d     = (state_d == S_COOL);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         grant_id_q    <= {IW{1'b0}};
         rr_ptr_q      <= {IW{1'b0}};
         wait_cnt_q    <= 1'b0;
         hold_cnt_q    <= {HW{1'b0}};
         cool_cnt_q    <= {CW{1'b0}};
         dig_q         <= {N{1'b0}};
         grant_valid_q <= 1'b0;
         revoke_q      <= 1'b0;
         cooling_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         rr_ptr_q      <= rr_ptr_d;
         wait_cnt_q    <= wait_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         cool_cnt_q    <= cool_cnt_d;
         dig_q         <= dig_d;
         grant_valid_q <= grant_valid_d;
         revoke_q      <= revoke_d;
         cooling_q     <= cooling_d;
      end
   end

   assign bus.dig         = dig_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.revoke      = revoke_q;
   assign bus.cooling     = cooling_q;

`ifdef LEMMINGS_ARB_STATS_EN
   logic [15:0] grant_count_q;
   logic [7:0]  revoke_count_q;

   // Saturating grant and revoke statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_count_q  <= 16'h0000;
         revoke_count_q <= 8'h00;
      end else begin
         if ((state_q == S_IDLE) && (state_d == S_GRANT) && (grant_count_q != 16'hFFFF)) begin
            grant_count_q <= grant_count_q + 16'h0001;
         end else begin
            grant_count_q <= grant_count_q;
         end
         if (revoke_d && (revoke_count_q != 8'hFF)) begin
            revoke_count_q <= revoke_count_q + 8'h01;
         end else begin
            revoke_count_q <= revoke_count_q;
         end
      end
   end

   assign bus.grant_count  = grant_count_q;
   assign bus.revoke_count = revoke_count_q;
`endif
endmodule

// File: tb/tb_lemmings_dig_arbiter.sv
// Scoreboard bench: a driver plays the lemmings and queues expected grants from a
// round-robin model; an independent monitor checks each grant's strobe, hold length and cooldown.
module tb_lemmings_dig_arbiter;
   localparam int N        = 4;
   localparam int COOLDOWN = 3;
   localparam int MAX_HOLD = 16;

   typedef struct {
      logic [N-1:0] dig;
      int           id;
      int           gv_len;
      bit           rev;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   lemmings_dig_arbiter_if #(.N(N)) bus ();

   lemmings_dig_arbiter #(.N(N), .COOLDOWN(COOLDOWN), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];
   int   model_ptr = 0;
   int   n_grants  = 0;
   int   n_revokes = 0;
   bit   mon_en    = 1'b1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: first requester at or after the pointer, wrapping
   function automatic int model_pick(input logic [N-1:0] m);
      for (int i = 0; i < N; i++) begin
         int j;
         j = (model_ptr + i) % N;
         if (m[j]) begin
            model_ptr = (j + 1) % N;
            return j;
         end
      end
      return -1;
   endfunction

   // k == 0: lemming never digs (abandon); else busy high for k cycles starting at WAIT cycle 1+d
   task automatic run_txn(input logic [N-1:0] mask, input int d, input int k, input int gap);
      int   win, h, e_idle, plan_end;
      exp_t e;
      repeat (gap) begin
         @(negedge clk);
         bus.req  = '0;
         bus.busy = N'($urandom);
      end
      @(negedge clk);
      bus.req  = mask;
      bus.busy = N'($urandom);
      win = model_pick(mask);
      if (k == 0) begin
         h        = 0;
         e.gv_len = 3;
         e.rev    = 1'b0;
         e_idle   = 4 + COOLDOWN;
         plan_end = 3;
      end else begin
         h        = (k > MAX_HOLD) ? MAX_HOLD : k;
         e.gv_len = 2 + d + h;
         e.rev    = (k > MAX_HOLD);
         e_idle   = 3 + d + h + COOLDOWN;
         plan_end = 2 + d + h;
      end
      e.dig = '0;
      e.dig[win] = 1'b1;
      e.id  = win;
      sb_q.push_back(e);
      n_grants++;
      if (e.rev) n_revokes++;
      for (int c = 1; c < e_idle; c++) begin
         @(negedge clk);
         bus.req  = N'($urandom);
         bus.busy = N'($urandom);
         if (c >= 2 && c <= plan_end) begin
            bus.busy[win] = (k > 0) && (c >= 2 + d) && (c < 2 + d + k);
         end
      end
   endtask

   // Monitor: pops one expectation per dig strobe and follows the grant to IDLE
   initial begin
      exp_t e;
      int   gv, cl, extra, extra_rev;
      forever begin
         @(negedge clk);
         if (!mon_en || reset) continue;
         if (bus.dig != '0) begin
            if (sb_q.size() == 0) begin
               check("unexpected_grant", bus.dig, 0);
            end else begin
               e = sb_q.pop_front();
               check("dig", bus.dig, e.dig);
               check("grant_id", bus.grant_id, e.id);
               gv = 0; extra = 0; extra_rev = 0;
               while (bus.grant_valid && gv < 200) begin
                  gv++;
                  @(negedge clk);
                  if (bus.grant_valid && bus.dig != '0) extra++;
               end
               check("grant_valid_len", gv, e.gv_len);
               check("dig_extra", extra, 0);
               check("revoke", bus.revoke, e.rev);
               check("grant_id_held", bus.grant_id, e.id);
               cl = 0;
               while (bus.cooling && cl < 200) begin
                  cl++;
                  @(negedge clk);
                  if (bus.revoke) extra_rev++;
               end
               check("cool_len", cl, COOLDOWN);
               check("revoke_extra", extra_rev, 0);
            end
         end else begin
            check("idle_outputs", {bus.grant_valid, bus.revoke, bus.cooling}, 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=%0t expected=finish", $time);
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b1;
      bus.req  = '0;
      bus.busy = '0;
      repeat (3) @(negedge clk);
      check("reset_dig", bus.dig, 0);
      check("reset_grant_id", bus.grant_id, 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_grant_id", bus.grant_id, 0);

      run_txn(4'b0100, 0, 5, 0);
      for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 2, 0);
      run_txn(4'b0010, 0, 0, 0);
      run_txn(4'b1111, 0, 3, 0);
      run_txn(4'b0001, 0, 40, 0);
      run_txn(4'b1111, 1, 2, 0);

      for (int t = 0; t < 150; t++) begin
         logic [N-1:0] m;
         int           k;
         m = N'($urandom);
         if (m == '0) m = 4'b0001 << $urandom_range(0, N - 1);
         k = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, MAX_HOLD + 3);
         run_txn(m, $urandom_range(0, 1), k, $urandom_range(0, 2));
      end

      @(negedge clk);
      bus.req = '0;
      mon_en  = 1'b0;
      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 0);
`ifdef LEMMINGS_ARB_STATS_EN
      check("grant_count", bus.grant_count, (n_grants > 65535) ? 65535 : n_grants);
      check("revoke_count", bus.revoke_count, (n_revokes > 255) ? 255 : n_revokes);
`endif

      // Reset mid-HOLD; winner 1 moves the arbiter pointer away from 0 first
      @(negedge clk);
      bus.req  = 4'b0010;
      bus.busy = '0;
      @(negedge clk);
      bus.req  = '0;
      bus.busy = 4'b0010;
      repeat (3) @(negedge clk);
      check("pre_reset_grant_valid", bus.grant_valid, 1);
      reset = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      bus.busy = '0;
      check("rst_hold_dig", bus.dig, 0);
      check("rst_hold_grant_valid", bus.grant_valid, 0);
      check("rst_hold_grant_id", bus.grant_id, 0);
      check("rst_hold_revoke", bus.revoke, 0);
      check("rst_hold_cooling", bus.cooling, 0);
`ifdef LEMMINGS_ARB_STATS_EN
      check("rst_grant_count", bus.grant_count, 0);
`endif
      bus.req = 4'b1111;
      @(negedge clk);
      bus.req = '0;
      check("post_reset_rr_dig", bus.dig, 4'b0001);

      // Reset during GRANT drops the strobe
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.req = 4'b0100;
      @(negedge clk);
      bus.req = '0;
      check("grant_dig", bus.dig, 4'b0100);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_grant_dig", bus.dig, 0);
      check("rst_grant_valid", bus.grant_valid, 0);
      repeat (2) @(negedge clk);
      check("rst_grant_stays_idle", bus.grant_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
